// File: rtl/board_move_scheduler_pkg.sv
// rtl/board_move_scheduler_pkg.sv - shared chess constants, scheduler states and move helpers
package board_move_scheduler_pkg;

  localparam int MOVE_W = 48;
  localparam int SQ_W   = 6;
  localparam int NCOLS  = 8;
  localparam int PTR_W  = $clog2(NCOLS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GEN,
    DRAIN,
    DONE
  } sched_state_t;

  // A move whose from-square equals its to-square terminates a column's list.
  function automatic logic is_end_move(input logic [MOVE_W-1:0] move);
    return move[2*SQ_W-1:SQ_W] == move[SQ_W-1:0];
  endfunction

endpackage

// File: rtl/board_move_scheduler_col_move_mux.sv
// rtl/board_move_scheduler_col_move_mux.sv - selects the FIFO head, empty and end flags of one column
module col_move_mux
  import board_move_scheduler_pkg::*;
(
  input  logic [NCOLS*MOVE_W-1:0] col_move,
  input  logic [NCOLS-1:0]        col_empty,
  input  logic [PTR_W-1:0]        col_ptr,
  output logic [MOVE_W-1:0]       head,
  output logic                    empty,
  output logic                    is_end
);

  assign head   = col_move[col_ptr*MOVE_W +: MOVE_W];
  assign empty  = col_empty[col_ptr];
  assign is_end = is_end_move(head);

endmodule

// File: rtl/board_move_scheduler.sv
// rtl/board_move_scheduler.sv - clears, waits on and drains the column move FIFOs onto one stream
// Optional watchdog on the GEN and DRAIN phases is built when WATCHDOG_EN is defined.
module board_move_scheduler
  import board_move_scheduler_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    gen_clear,
  input  logic [NCOLS-1:0]        col_done,
  input  logic [NCOLS-1:0]        col_empty,
  input  logic [NCOLS*MOVE_W-1:0] col_move,
  output logic [NCOLS-1:0]        col_rden,
  output logic                    mv_valid,
  input  logic                    mv_ready,
  output logic [MOVE_W-1:0]       mv_data,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        move_count,
  output logic                    timeout
);

  sched_state_t      state, state_nxt;
  logic [PTR_W-1:0]  col_ptr;
  logic [CNT_W-1:0]  count_r;
  logic [MOVE_W-1:0] head;
  logic              head_empty, head_end;
  logic              pop, accept, last_col;

  col_move_mux u_mux (
    .col_move  (col_move),
    .col_empty (col_empty),
    .col_ptr   (col_ptr),
    .head      (head),
    .empty     (head_empty),
    .is_end    (head_end)
  );

  assign last_col = (col_ptr == PTR_W'(NCOLS-1));

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire, timeout_r;

  assign wd_fire = ((state == GEN) || (state == DRAIN)) && (wd_cnt == WD_W'(TIMEOUT_CYCLES-1));
  assign timeout = timeout_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (pop || ((state_nxt != state) && ((state_nxt == GEN) || (state_nxt == DRAIN))))
        wd_cnt <= '0;
      else if ((state == GEN) || (state == DRAIN))
        wd_cnt <= wd_cnt + 1'b1;
      if (state == CLEAR)
        timeout_r <= 1'b0;
      else if (wd_fire)
        timeout_r <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gen_clear = 1'b0;
    col_rden  = '0;
    mv_valid  = 1'b0;
    pop       = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: begin
        gen_clear = 1'b1;
        state_nxt = GEN;
      end
      GEN:   if (&col_done) state_nxt = DRAIN;
      DRAIN: begin
        if (!head_empty) begin
          if (head_end) begin
            col_rden[col_ptr] = 1'b1;
            pop = 1'b1;
            if (last_col) state_nxt = DONE;
          end else begin
            mv_valid = 1'b1;
            if (mv_ready) begin
              col_rden[col_ptr] = 1'b1;
              pop    = 1'b1;
              accept = 1'b1;
            end
          end
        end
      end
      DONE:  if (start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
`ifdef WATCHDOG_EN
    if (wd_fire) state_nxt = DONE;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      col_ptr <= '0;
      count_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        col_ptr <= '0;
        count_r <= '0;
      end else begin
        // col_ptr parks on the last column rather than wrapping.
        if (pop && head_end && !last_col) col_ptr <= col_ptr + 1'b1;
        if (accept && (count_r != {CNT_W{1'b1}})) count_r <= count_r + 1'b1;
      end
    end
  end

  assign mv_data    = mv_valid ? head : '0;
  assign busy       = (state == CLEAR) || (state == GEN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign move_count = count_r;

endmodule

// File: tb/tb_board_move_scheduler.sv
// tb/tb_board_move_scheduler.sv - randomized column-FIFO model and scoreboard for board_move_scheduler
module tb_board_move_scheduler;
  import board_move_scheduler_pkg::*;

  localparam int CNT_W = 8;
  localparam int DEPTH = 256;
`ifdef WATCHDOG_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 4096;
`endif

  logic                    clk = 1'b0, reset = 1'b0, start = 1'b0, mv_ready = 1'b0;
  logic                    gen_clear, mv_valid, busy, done, timeout;
  logic [NCOLS-1:0]        col_done = '0, col_empty = '1, col_rden;
  logic [NCOLS*MOVE_W-1:0] col_move = '0;
  logic [MOVE_W-1:0]       mv_data;
  logic [CNT_W-1:0]        move_count;

  int n_checks = 0, n_errors = 0;

  logic [MOVE_W-1:0] mem [NCOLS][DEPTH];
  int                wr_idx [NCOLS];
  int                rd_idx [NCOLS];
  logic              flush_req = 1'b0;
  int                ready_mode = 0;
  int                ncnt [NCOLS];

  logic [MOVE_W-1:0] exp_q[$];
  logic [MOVE_W-1:0] got_q[$];
  int                pops = 0, clears = 0;
  logic [NCOLS-1:0]  pend_rden = '0;
  logic              prev_stall = 1'b0;
  logic [MOVE_W-1:0] prev_data = '0;

  board_move_scheduler #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .gen_clear  (gen_clear),
    .col_done   (col_done),
    .col_empty  (col_empty),
    .col_move   (col_move),
    .col_rden   (col_rden),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .mv_data    (mv_data),
    .busy       (busy),
    .done       (done),
    .move_count (move_count),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MOVE_W-1:0] make_move(input bit is_end);
    logic [63:0]       rnd;
    logic [MOVE_W-1:0] m;
    int                from, to;
    rnd  = {$urandom, $urandom};
    from = $urandom_range(0, 63);
    to   = is_end ? from : (from + $urandom_range(1, 63)) % 64;
    m          = rnd[MOVE_W-1:0];
    m[11:6]    = 6'(from);
    m[5:0]     = 6'(to);
    return m;
  endfunction

  // Column FIFOs: pop what the DUT strobed at the previous edge, then present new heads.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCOLS; c++) begin
      if (flush_req) rd_idx[c] = wr_idx[c];
      else if (reset && pend_rden[c] && (rd_idx[c] < wr_idx[c])) rd_idx[c]++;
      col_empty[c] = (rd_idx[c] >= wr_idx[c]);
      col_move[c*MOVE_W +: MOVE_W] = col_empty[c] ? '0 : mem[c][rd_idx[c]];
    end
    case (ready_mode)
      0:       mv_ready = 1'b1;
      1:       mv_ready = ~mv_ready;
      default: mv_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      pend_rden  = '0;
      prev_stall = 1'b0;
    end else begin
      pend_rden = col_rden;
      pops += $countones(col_rden);
      if (gen_clear) clears++;
      if (col_rden != '0) check_eq("rden_onehot", $countones(col_rden), 1);
      if (col_rden != '0) check_eq("rden_in_drain", busy && !gen_clear, 1);
      if (mv_valid) check_eq("rden_on_accept", col_rden != '0, mv_ready);
      if (prev_stall) check_eq("stall_hold", {mv_valid, mv_data}, {1'b1, prev_data});
      if (mv_valid && mv_ready) got_q.push_back(mv_data);
      prev_stall = mv_valid && !mv_ready;
      prev_data  = mv_data;
    end
  end

  task automatic load_columns(output int total);
    logic [MOVE_W-1:0] m;
    exp_q.delete();
    total = 0;
    for (int c = 0; c < NCOLS; c++) begin
      for (int k = 0; k < ncnt[c]; k++) begin
        m = make_move(1'b0);
        mem[c][wr_idx[c]] = m;
        wr_idx[c]++;
        exp_q.push_back(m);
        total++;
      end
      mem[c][wr_idx[c]] = make_move(1'b1);
      wr_idx[c]++;
    end
  endtask

  task automatic kick_pass(input int mode, input string nm);
    ready_mode = mode;
    col_done   = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({nm, "_gen_clear"}, gen_clear, 1);
    tick();
    tick();
    col_done = '1;
  endtask

  task automatic run_pass(input int mode, input string nm);
    int total, base_got, base_pops, base_clr, bound, ngot, sat;
    base_got  = got_q.size();
    base_pops = pops;
    base_clr  = clears;
    load_columns(total);
    tick();
    kick_pass(mode, nm);
    bound = 0;
    while (!done && bound < 20000) begin
      tick();
      bound++;
    end
    check_eq({nm, "_done"}, done, 1);
    check_eq({nm, "_busy"}, busy, 0);
    ngot = got_q.size() - base_got;
    check_eq({nm, "_num_moves"}, ngot, total);
    for (int i = 0; i < ngot && i < total; i++)
      check_eq({nm, "_move_seq"}, got_q[base_got+i], exp_q[i]);
    sat = (total > 255) ? 255 : total;
    check_eq({nm, "_move_count"}, move_count, sat);
    check_eq({nm, "_pops"}, pops - base_pops, total + NCOLS);
    check_eq({nm, "_gen_clear_cnt"}, clears - base_clr, 1);
    check_eq({nm, "_timeout"}, timeout, 0);
    check_eq({nm, "_fifos_empty"}, col_empty, {NCOLS{1'b1}});
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int bound, total, base_got, base_pops, k;
    for (int c = 0; c < NCOLS; c++) begin
      wr_idx[c] = 0;
      rd_idx[c] = 0;
    end
    #1;
    check_eq("rst_gen_clear", gen_clear, 0);
    check_eq("rst_rden", col_rden, 0);
    check_eq("rst_valid", mv_valid, 0);
    check_eq("rst_busy_done", {busy, done}, 0);
    check_eq("rst_count_timeout", {move_count, timeout}, 0);
    tick();
    tick();
    reset = 1'b1;

    // Reset in the middle of column 3's drain.
    for (int c = 0; c < NCOLS; c++) ncnt[c] = 2;
    base_got = got_q.size();
    load_columns(total);
    tick();
    kick_pass(2, "midrst");
    bound = 0;
    while ((got_q.size() - base_got) < 7 && bound < 5000) begin
      tick();
      bound++;
    end
    check_eq("midrst_reached_col3", got_q.size() - base_got, 7);
    check_eq("midrst_busy_before", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_gen_clear", gen_clear, 0);
    check_eq("midrst_rden", col_rden, 0);
    check_eq("midrst_valid_data", {mv_valid, mv_data}, 0);
    check_eq("midrst_busy_done", {busy, done}, 0);
    check_eq("midrst_count", move_count, 0);
    check_eq("midrst_timeout", timeout, 0);
    flush_req = 1'b1;
    tick();
    tick();
    flush_req = 1'b0;
    reset = 1'b1;
    tick();
    run_pass(0, "after_rst");

    for (int c = 0; c < NCOLS; c++) ncnt[c] = 2;
    run_pass(0, "full_ready");
    run_pass(1, "toggle_ready");

    for (int c = 0; c < NCOLS; c++) ncnt[c] = 0;
    ncnt[NCOLS-1] = 1;
    run_pass(2, "only_col7");

    for (int c = 0; c < NCOLS; c++) ncnt[c] = (c < 4) ? 37 : 38;
    run_pass(2, "saturate");

    for (int c = 0; c < NCOLS; c++) ncnt[c] = $urandom_range(0, 5);
    run_pass(2, "random");

`ifdef WATCHDOG_EN
    base_pops  = pops;
    ready_mode = 0;
    col_done   = 8'h7F;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wd_gen_clear", gen_clear, 1);
    tick();
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    check_eq("wd_cycles", k, 16);
    check_eq("wd_timeout", timeout, 1);
    check_eq("wd_done", done, 1);
    check_eq("wd_no_rden", pops - base_pops, 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
